// File: rtl/umi_arb_pkg.sv
// Shared UMI opcode constants and field positions used by the output arbiter.
package umi_arb_pkg;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 8;

  typedef logic [OPCODE_W-1:0] umi_opcode_t;

  localparam umi_opcode_t READ_REQUEST = 8'h01;
  localparam umi_opcode_t WRITE_POSTED = 8'h05;

endpackage

// File: rtl/umi_rr_pick.sv
// Pointer-relative first-one search: lowest set mask bit at or after ptr, wrapping N-1 to 0.
module umi_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] index,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    int unsigned   s;
    logic [IW-1:0] j;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    s      = 0;
    j      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      s = 32'(ptr) + k;
      if (s >= N) s = s - N;
      j = IW'(s);
      if (!any && mask[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        index     = j;
      end
    end
  end

endmodule

// File: rtl/umi_out_arbiter.sv
// N-to-1 UMI arbiter with a single registered output stage and round-robin grant.
// Optional UMI_ARB_WRITE_PRIO_EN: posted writes win, bounded by a starvation counter.
module umi_out_arbiter
  import umi_arb_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned PW         = 256,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*PW-1:0]      req_packet,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  output logic [PW-1:0]        umi_out_packet,
  output logic                 umi_out_valid,
  input  logic                 umi_out_ready,
  output logic [$clog2(N)-1:0] umi_out_src
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          free;
  logic          accept;
  logic [N-1:0]  gnt_onehot;
  logic [IW-1:0] gnt_index;
  logic          gnt_any;

  assign free = !umi_out_valid || umi_out_ready;

`ifdef UMI_ARB_WRITE_PRIO_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 2);

  logic [CW-1:0] starve_cnt;
  logic [N-1:0]  write_mask;
  logic [N-1:0]  other_mask;
  logic [N-1:0]  full_mask;
  logic          force_rr;
  logic          prio_gnt;
  logic [N-1:0]  w_onehot;
  logic [N-1:0]  f_onehot;
  logic [IW-1:0] w_index;
  logic [IW-1:0] f_index;
  logic          w_any;
  logic          f_any;

  always_comb begin
    write_mask = '0;
    for (int unsigned i = 0; i < N; i++)
      write_mask[i] = req_valid[i] &&
        (req_packet[i*PW + OPCODE_LSB +: OPCODE_W] == WRITE_POSTED);
  end

  assign other_mask = req_valid & ~write_mask;
  assign force_rr   = starve_cnt >= CW'(STARVE_MAX);
  // The forced slot goes to a waiting non-write requester so it cannot starve.
  assign full_mask  = (force_rr && |other_mask) ? other_mask : req_valid;
  assign prio_gnt   = w_any && !force_rr;

  umi_rr_pick #(.N(N)) u_pick_write (
    .mask   (write_mask),
    .ptr    (ptr),
    .onehot (w_onehot),
    .index  (w_index),
    .any    (w_any)
  );

  umi_rr_pick #(.N(N)) u_pick_full (
    .mask   (full_mask),
    .ptr    (ptr),
    .onehot (f_onehot),
    .index  (f_index),
    .any    (f_any)
  );

  assign gnt_onehot = prio_gnt ? w_onehot : f_onehot;
  assign gnt_index  = prio_gnt ? w_index  : f_index;
  assign gnt_any    = prio_gnt ? w_any    : f_any;

  // Consecutive write-priority grants that bypassed a waiting non-write requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (!prio_gnt)        starve_cnt <= '0;
      else if (|other_mask) starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  umi_rr_pick #(.N(N)) u_pick_full (
    .mask   (req_valid),
    .ptr    (ptr),
    .onehot (gnt_onehot),
    .index  (gnt_index),
    .any    (gnt_any)
  );
`endif

  assign req_ready = (rst_n && free && gnt_any) ? gnt_onehot : '0;
  assign accept    = |(req_ready & req_valid);

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      umi_out_valid  <= 1'b0;
      umi_out_packet <= '0;
      umi_out_src    <= '0;
      ptr            <= '0;
    end else if (accept) begin
      umi_out_valid  <= 1'b1;
      umi_out_packet <= req_packet[32'(gnt_index)*PW +: PW];
      umi_out_src    <= gnt_index;
      ptr            <= (gnt_index == IW'(N-1)) ? '0 : gnt_index + IW'(1);
    end else if (umi_out_ready) begin
      umi_out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_umi_out_arbiter.sv
// Randomized and directed bench for umi_out_arbiter with a queue scoreboard and rule-level model.
module tb_umi_out_arbiter;
  import umi_arb_pkg::*;

  localparam int N  = 4;
  localparam int PW = 64;
  localparam int SM = 8;
  localparam int TW = N * PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [TW-1:0] req_packet;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [PW-1:0] umi_out_packet;
  logic          umi_out_valid;
  logic          umi_out_ready;
  logic [1:0]    umi_out_src;

  umi_out_arbiter #(.N(N), .PW(PW), .STARVE_MAX(SM)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_packet     (req_packet),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .umi_out_packet (umi_out_packet),
    .umi_out_valid  (umi_out_valid),
    .umi_out_ready  (umi_out_ready),
    .umi_out_src    (umi_out_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            src;
    logic [PW-1:0] pkt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests;
  int          fails;
  int          mptr;
  int          mcnt;
  bit          mvalid;
  logic [7:0]  opc [N];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] port_pkt(input int i);
    return PW'(req_packet >> (i * PW));
  endfunction

  function automatic int first_from(input logic [N-1:0] m, input int p);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = m >> ((p + k) % N);
      if (t[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference: decide this cycle's grant from the arbitration rules and queue the expected packet.
  task automatic model_cycle();
    int           g;
    logic [N-1:0] er;
`ifdef UMI_ARB_WRITE_PRIO_EN
    logic [N-1:0]  wm;
    logic [N-1:0]  om;
    logic [PW-1:0] p;
`endif
    check("out_valid", PW'(umi_out_valid), PW'(mvalid));
    g = -1;
    if (!mvalid || umi_out_ready) begin
`ifdef UMI_ARB_WRITE_PRIO_EN
      wm = '0;
      for (int i = 0; i < N; i++) begin
        p = port_pkt(i);
        if (req_valid[i] && p[7:0] == WRITE_POSTED) wm = wm | (N'(1) << i);
      end
      om = req_valid & ~wm;
      if (mcnt >= SM) begin
        g = first_from((om != 0) ? om : req_valid, mptr);
        if (g >= 0) mcnt = 0;
      end else if (wm != 0) begin
        g = first_from(wm, mptr);
        if (om != 0) mcnt++;
      end else begin
        g = first_from(req_valid, mptr);
        if (g >= 0) mcnt = 0;
      end
`else
      g = first_from(req_valid, mptr);
`endif
    end
    er = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", PW'(req_ready), PW'(er));
    if (g >= 0) begin
      sb.push_back('{g, port_pkt(g)});
      mptr   = (g + 1) % N;
      mvalid = 1'b1;
    end else if (umi_out_ready) begin
      mvalid = 1'b0;
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic rdy);
    logic [PW-1:0] p;
    logic [TW-1:0] rp;
    @(posedge clk);
    #1;
    rp = '0;
    for (int i = 0; i < N; i++) begin
      p = {$urandom, $urandom};
      p[7:0] = opc[i];
      rp = rp | (TW'(p) << (i * PW));
    end
    req_packet    = rp;
    req_valid     = v;
    umi_out_ready = rdy;
    @(negedge clk);
    model_cycle();
  endtask

  // Monitor: every output handshake must match the oldest expected packet.
  always @(negedge clk) begin
    if (rst_n && umi_out_valid && umi_out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got src %0d pkt %0h expected none", umi_out_src, umi_out_packet);
      end else begin
        mon_e = sb.pop_front();
        check("out_src", PW'(umi_out_src), PW'(mon_e.src));
        check("out_pkt", umi_out_packet, mon_e.pkt);
      end
    end
  end

  initial begin
    tests = 0; fails = 0; mptr = 0; mcnt = 0; mvalid = 1'b0;
    for (int i = 0; i < N; i++) opc[i] = READ_REQUEST;
    req_valid = '1; umi_out_ready = 1'b1; req_packet = '1;
    #12;
    check("rst_valid", PW'(umi_out_valid), '0);
    check("rst_src", PW'(umi_out_src), '0);
    check("rst_pkt", umi_out_packet, '0);
    check("rst_ready", PW'(req_ready), '0);
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // All requesters valid: grants rotate 0,1,2,3,0.
    for (int c = 0; c < 5; c++) begin
      step('1, 1'b1);
      check("rr_seq", PW'(req_ready), PW'(N'(1) << (c % N)));
    end
    step('0, 1'b1);

    // Stalled output: requester 2 accepted once and held.
    step(4'b0100, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(4'b0100, 1'b0);
      check("stall_ready", PW'(req_ready), '0);
      check("stall_src", PW'(umi_out_src), PW'(2));
    end
    step('0, 1'b1);

    // Single requester 3 streaming without bubbles.
    for (int c = 0; c < 8; c++) begin
      step(4'b1000, 1'b1);
      check("stream_ready", PW'(req_ready), PW'(4'b1000));
    end
    step('0, 1'b1);

    // Requester 1 pulses while requester 0 wins.
    step(4'b0011, 1'b1);
    check("pulse_ready", PW'(req_ready), PW'(4'b0001));
    step(4'b0001, 1'b1);
    step('0, 1'b1);

    // Reset while holding a packet.
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", PW'(umi_out_valid), '0);
    check("async_rst_ready", PW'(req_ready), '0);
    req_valid = '0;
    sb.delete();
    mptr = 0; mcnt = 0; mvalid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    step('1, 1'b1);
    check("ptr_after_rst", PW'(req_ready), PW'(4'b0001));

`ifdef UMI_ARB_WRITE_PRIO_EN
    // Requester 0 reads while 1..3 write continuously; 9th grant goes to 0.
    opc[0] = READ_REQUEST;
    for (int i = 1; i < N; i++) opc[i] = WRITE_POSTED;
    for (int k = 1; k <= 9; k++) begin
      step('1, 1'b1);
      check("starve_grant", PW'(req_ready),
            (k < 9) ? PW'(N'(1) << (((k - 1) % 3) + 1)) : PW'(4'b0001));
    end
`endif

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) opc[i] = ($urandom_range(0, 1) != 0) ? WRITE_POSTED : READ_REQUEST;
      step(N'($urandom), ($urandom_range(0, 3) != 0));
    end

    for (int c = 0; c < 3; c++) step('0, 1'b1);
    check("sb_empty", PW'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
